// File: rtl/invsqrt_req_seq.sv
// ---------------------------------------------------------------------------
// invsqrt_req_seq
//
// Host-side request sequencer for the fixed-point inverse-square-root engine.
// Operands pushed by software into a command FIFO are issued one at a time
// to the engine's valid/ready input port. Each result is collected from the
// engine's valid/ready output port into a response FIFO for the host to pop.
// A zero operand never reaches the engine. It is answered directly with
// all-ones, the saturated value of 1/sqrt(0).
//
// Parameters
//   DATA_WIDTH    operand/result width (Q12.4 in the default build)
//   DEPTH         entries per FIFO (power of 2, >= 2)
//
// Ports
//   clk           single clock, rising edge
//   rst           asynchronous active-low reset
//   cmd_data      operand to push
//   cmd_wr        push strobe
//   cmd_full      command FIFO full
//   rsp_data      head of response FIFO (valid when !rsp_empty)
//   rsp_rd        pop strobe
//   rsp_empty     response FIFO empty
//   eng_data_in   operand to engine
//   eng_valid_in  operand valid
//   eng_ready_in  engine accepts operand
//   eng_data_out  engine result
//   eng_valid_out result valid
//   eng_ready_out sequencer accepts result
//   busy          FSM active or commands pending
//   err_ovf       sticky: push while command FIFO full
//   err_udf       sticky: pop while response FIFO empty
//   err_clr       synchronous clear of both sticky flags
// ---------------------------------------------------------------------------
module invsqrt_req_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic                  cmd_wr,
    output logic                  cmd_full,
    output logic [DATA_WIDTH-1:0] rsp_data,
    input  logic                  rsp_rd,
    output logic                  rsp_empty,
    output logic [DATA_WIDTH-1:0] eng_data_in,
    output logic                  eng_valid_in,
    input  logic                  eng_ready_in,
    input  logic [DATA_WIDTH-1:0] eng_data_out,
    input  logic                  eng_valid_out,
    output logic                  eng_ready_out,
    output logic                  busy,
    output logic                  err_ovf,
    output logic                  err_udf,
    input  logic                  err_clr
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        ZERO
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] operand;

    logic [DATA_WIDTH-1:0] cmd_mem [DEPTH];
    logic [AW:0]           cmd_wr_ptr;
    logic [AW:0]           cmd_rd_ptr;
    logic [DATA_WIDTH-1:0] rsp_mem [DEPTH];
    logic [AW:0]           rsp_wr_ptr;
    logic [AW:0]           rsp_rd_ptr;

    logic                  cmd_empty;
    logic                  rsp_full;
    logic                  cmd_push;
    logic                  cmd_pop;
    logic                  rsp_push;
    logic                  rsp_pop;
    logic [DATA_WIDTH-1:0] rsp_push_data;
    logic [DATA_WIDTH-1:0] cmd_head;

    // Status is decoded from the registered pointers. The extra wrap bit
    // tells a full FIFO apart from an empty one when the index bits match.
    assign cmd_empty = (cmd_wr_ptr == cmd_rd_ptr);
    assign cmd_full  = ((cmd_wr_ptr ^ cmd_rd_ptr) == {1'b1, {AW{1'b0}}});
    assign rsp_empty = (rsp_wr_ptr == rsp_rd_ptr);
    assign rsp_full  = ((rsp_wr_ptr ^ rsp_rd_ptr) == {1'b1, {AW{1'b0}}});

    assign cmd_head  = cmd_mem[cmd_rd_ptr[AW-1:0]];
    assign rsp_data  = rsp_mem[rsp_rd_ptr[AW-1:0]];

    // A push is judged against the pre-edge full flag, so a pop by the FSM
    // in the same cycle does not make room for it.
    assign cmd_push = cmd_wr && !cmd_full;
    assign rsp_pop  = rsp_rd && !rsp_empty;

    // Issue only when a response slot is free. With a single result in
    // flight, this keeps the response FIFO from ever overflowing.
    assign cmd_pop  = (state == IDLE) && !cmd_empty && !rsp_full;

    assign rsp_push = (((state == WAIT) && eng_valid_out && eng_ready_out) ||
                       (state == ZERO)) && !rsp_full;
    assign rsp_push_data = (state == ZERO) ? {DATA_WIDTH{1'b1}} : eng_data_out;

    assign busy = (state != IDLE) || !cmd_empty;

    // Storage arrays carry no reset. Only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wr_ptr[AW-1:0]] <= cmd_data;
        end
        if (rsp_push) begin
            rsp_mem[rsp_wr_ptr[AW-1:0]] <= rsp_push_data;
        end
    end

    // Pointer updates for both FIFOs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_wr_ptr <= '0;
            cmd_rd_ptr <= '0;
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
        end else begin
            if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + (AW+1)'(1);
            if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + (AW+1)'(1);
            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + (AW+1)'(1);
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + (AW+1)'(1);
        end
    end

    // Sticky error flags. A new error event in the same cycle as err_clr
    // wins over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            err_ovf <= (cmd_wr && cmd_full) || (err_ovf && !err_clr);
            err_udf <= (rsp_rd && rsp_empty) || (err_udf && !err_clr);
        end
    end

    // Request FSM. ISSUE raises eng_valid_in one cycle after entry, so the
    // operand is registered on the engine port before it is offered.
    // eng_ready_out rises on the same edge that leaves ISSUE, so it is
    // already high on entry to WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            operand       <= '0;
            eng_valid_in  <= 1'b0;
            eng_data_in   <= '0;
            eng_ready_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_pop) begin
                        operand <= cmd_head;
                        state   <= (cmd_head == '0) ? ZERO : ISSUE;
                    end
                end
                ISSUE: begin
                    if (!eng_valid_in) begin
                        eng_valid_in <= 1'b1;
                        eng_data_in  <= operand;
                    end else if (eng_ready_in) begin
                        eng_valid_in  <= 1'b0;
                        eng_ready_out <= 1'b1;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (eng_valid_out && eng_ready_out) begin
                        eng_ready_out <= 1'b0;
                        state         <= IDLE;
                    end
                end
                ZERO: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_invsqrt_req_seq.sv
// ---------------------------------------------------------------------------
// tb_invsqrt_req_seq
//
// Bench for invsqrt_req_seq. It contains a behavioural engine with two
// modes, a real Q12.4 inverse square root and a stub that returns ~operand.
// The engine uses random ready gaps and a random latency of 1-10 cycles.
// Expected responses come from a queue of expected results in command order.
// ---------------------------------------------------------------------------
module tb_invsqrt_req_seq;

    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] cmd_data;
    logic          cmd_wr;
    logic          cmd_full;
    logic [DW-1:0] rsp_data;
    logic          rsp_rd;
    logic          rsp_empty;
    logic [DW-1:0] eng_data_in;
    logic          eng_valid_in;
    logic          eng_ready_in;
    logic [DW-1:0] eng_data_out;
    logic          eng_valid_out;
    logic          eng_ready_out;
    logic          busy;
    logic          err_ovf;
    logic          err_udf;
    logic          err_clr;

    typedef struct {
        logic [15:0] val;
        int          tol;
    } exp_t;

    exp_t        expQ[$];
    logic [15:0] issueQ[$];

    int          errors = 0;
    int          checks = 0;
    bit          realMode = 1'b1;
    bit          engStall = 1'b0;
    bit          engHoldOut = 1'b0;
    bit          checkNoIssue = 1'b0;
    int          hsCount = 0;
    bit          outstanding = 1'b0;
    bit          hsNext = 1'b0;
    bit          accNext = 1'b0;
    logic [15:0] hsData = '0;
    logic [15:0] lastPop = '0;

    invsqrt_req_seq #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_data      (cmd_data),
        .cmd_wr        (cmd_wr),
        .cmd_full      (cmd_full),
        .rsp_data      (rsp_data),
        .rsp_rd        (rsp_rd),
        .rsp_empty     (rsp_empty),
        .eng_data_in   (eng_data_in),
        .eng_valid_in  (eng_valid_in),
        .eng_ready_in  (eng_ready_in),
        .eng_data_out  (eng_data_out),
        .eng_valid_out (eng_valid_out),
        .eng_ready_out (eng_ready_out),
        .busy          (busy),
        .err_ovf       (err_ovf),
        .err_udf       (err_udf),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    // 1/sqrt(x) in Q12.4: (16 / sqrt(x/16)) rounded, i.e. 64/sqrt(x).
    function automatic logic [15:0] invsqrtRef(input logic [15:0] x);
        real r;
        if (x == 16'h0) return 16'hFFFF;
        r = 64.0 / $sqrt(real'(x));
        return 16'($rtoi(r + 0.5));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkNear(input string name, input logic [15:0] actual,
                             input logic [15:0] expected, input int tol);
        int d;
        checks++;
        d = int'(actual) - int'(expected);
        if (d < 0) d = -d;
        if ($isunknown(actual) || d > tol) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h +/- %0d", name, actual, expected, tol);
        end
    endtask

    task automatic failNow(input string name, input int actual, input int expected);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Record the result the sequencer must eventually return for an operand.
    task automatic modelPush(input logic [15:0] d);
        exp_t e;
        if (d == 16'h0) begin
            e.val = 16'hFFFF;
            e.tol = 0;
        end else if (realMode) begin
            e.val = invsqrtRef(d);
            e.tol = 2;
            issueQ.push_back(d);
        end else begin
            e.val = ~d;
            e.tol = 0;
            issueQ.push_back(d);
        end
        expQ.push_back(e);
    endtask

    // Engine: accepts an operand, waits 1-10 cycles, then offers the result
    // until taken. Driven shortly after each rising edge.
    initial begin
        int          lat;
        bit          holding;
        logic [15:0] op;
        lat = 0;
        holding = 1'b0;
        op = '0;
        eng_ready_in  = 1'b0;
        eng_valid_out = 1'b0;
        eng_data_out  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                eng_ready_in  = 1'b0;
                eng_valid_out = 1'b0;
                holding = 1'b0;
            end else begin
                if (accNext) eng_valid_out = 1'b0;
                if (hsNext) begin
                    op = hsData;
                    holding = 1'b1;
                    lat = $urandom_range(1, 10);
                end
                if (holding && !eng_valid_out && !engHoldOut) begin
                    if (lat > 0) begin
                        lat--;
                    end else if ($urandom_range(0, 2) != 0) begin
                        eng_valid_out = 1'b1;
                        eng_data_out  = realMode ? invsqrtRef(op) : ~op;
                        holding = 1'b0;
                    end
                end
                eng_ready_in = !engStall && ($urandom_range(0, 3) != 0);
            end
        end
    end

    // Compare process. At each falling edge, inputs and outputs are stable.
    // It checks what the next rising edge will do against the model.
    always @(negedge clk) begin : compareProc
        exp_t        e;
        bit          prevPending;
        logic [15:0] prevData;
        hsNext  = 1'b0;
        accNext = 1'b0;
        if (!rst) begin
            prevPending = 1'b0;
        end else begin
            if (prevPending) begin
                checkOutput("valid_hold", {15'h0, eng_valid_in, eng_data_in}, {15'h0, 1'b1, prevData});
            end
            if (rsp_rd && !rsp_empty) begin
                if (expQ.size() == 0) begin
                    failNow("unexpected_rsp", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkNear("rsp_data", rsp_data, e.val, e.tol);
                end
                lastPop = rsp_data;
            end
            if (eng_valid_in && eng_ready_in) begin
                checkOutput("single_outstanding", 32'(outstanding), 0);
                if (issueQ.size() == 0) failNow("unexpected_issue", 1, 0);
                else checkOutput("issue_order", eng_data_in, issueQ.pop_front());
                hsNext = 1'b1;
                hsData = eng_data_in;
                hsCount++;
                outstanding = 1'b1;
            end
            if (eng_valid_out && eng_ready_out) begin
                accNext = 1'b1;
                outstanding = 1'b0;
            end
            if (checkNoIssue) checkOutput("no_issue", 32'(eng_valid_in), 0);
            prevPending = eng_valid_in && !eng_ready_in;
            prevData = eng_data_in;
        end
    end

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit wr, input logic [15:0] data, input bit rd,
                                 input bit clr, input bit expectAccept);
        cmd_wr   = wr;
        cmd_data = data;
        rsp_rd   = rd;
        err_clr  = clr;
        if (wr && expectAccept) modelPush(data);
        cycle();
        cmd_wr  = 1'b0;
        rsp_rd  = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic checkResetState();
        checkOutput("rst_eng_valid_in", 32'(eng_valid_in), 0);
        checkOutput("rst_eng_ready_out", 32'(eng_ready_out), 0);
        checkOutput("rst_eng_data_in", eng_data_in, 0);
        checkOutput("rst_cmd_full", 32'(cmd_full), 0);
        checkOutput("rst_rsp_empty", 32'(rsp_empty), 1);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_err_ovf", 32'(err_ovf), 0);
        checkOutput("rst_err_udf", 32'(err_udf), 0);
    endtask

    task automatic waitRsp(input int budget);
        int n = 0;
        while (rsp_empty && n < budget) begin
            cycle();
            n++;
        end
        if (rsp_empty) failNow("rsp_timeout", n, budget);
    endtask

    task automatic waitHs(input int target, input int budget);
        int n = 0;
        while ((hsCount < target || outstanding) && n < budget) begin
            cycle();
            n++;
        end
        if (hsCount < target || outstanding) failNow("handshake_timeout", hsCount, target);
    endtask

    task automatic pushWhenRoom(input logic [15:0] d, input int budget);
        int n = 0;
        while (cmd_full && n < budget) begin
            cycle();
            n++;
        end
        if (cmd_full) failNow("cmd_room_timeout", n, budget);
        else applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (expQ.size() > 0 && n < budget) begin
            applyStimulus(1'b0, 16'h0, !rsp_empty && ($urandom_range(0, 3) != 0), 1'b0, 1'b0);
            n++;
        end
        if (expQ.size() > 0) failNow("drain_timeout", expQ.size(), 0);
        checkOutput("drain_rsp_empty", 32'(rsp_empty), 1);
    endtask

    // Single operand through the real engine, with issue-latency checks.
    task automatic realOp(input logic [15:0] op, input logic [15:0] lit, input string name);
        int hs0 = hsCount;
        applyStimulus(1'b1, op, 1'b0, 1'b0, 1'b1);
        cycle();
        checkOutput("issue_lat_n1", 32'(eng_valid_in), 0);
        cycle();
        checkOutput("issue_lat_n2", 32'(eng_valid_in), 1);
        waitRsp(200);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkNear(name, lastPop, lit, 2);
        checkOutput("one_handshake", hsCount - hs0, 1);
    endtask

    task automatic randomPhase(input int nOps);
        int pushed = 0;
        for (int c = 0; c < 2000 && pushed < nOps; c++) begin
            bit          wr = !cmd_full && ($urandom_range(0, 2) != 0);
            logic [15:0] d  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            bit          rd = !rsp_empty && ($urandom_range(0, 1) == 1);
            applyStimulus(wr, d, rd, 1'b0, 1'b1);
            if (wr) pushed++;
        end
        drain(5000);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hsBase;
        rst = 1'b0;
        cmd_wr = 1'b0;
        cmd_data = '0;
        rsp_rd = 1'b0;
        err_clr = 1'b0;

        // Reset held for 3 cycles with random host inputs.
        for (int i = 0; i < 3; i++) begin
            cmd_wr   = 1'($urandom);
            cmd_data = 16'($urandom);
            rsp_rd   = 1'($urandom);
            err_clr  = 1'($urandom);
            cycle();
            checkResetState();
        end
        cmd_wr = 1'b0;
        rsp_rd = 1'b0;
        err_clr = 1'b0;
        rst = 1'b1;
        cycle();
        checkResetState();

        // Real engine, single operands.
        realMode = 1'b1;
        realOp(16'h0008, 16'h0017, "real_0p5");
        realOp(16'h0018, 16'h000D, "real_1p5");
        realOp(16'h0177, 16'h0003, "real_23p4");

        // Zero operand never reaches the engine.
        hsBase = hsCount;
        checkNoIssue = 1'b1;
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1);
        waitRsp(50);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkNoIssue = 1'b0;
        checkOutput("zero_result", lastPop, 16'hFFFF);
        checkOutput("zero_no_handshake", hsCount - hsBase, 0);

        // Underflow flag, set-beats-clear, then clear.
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("udf_set", 32'(err_udf), 1);
        checkOutput("udf_no_ovf", 32'(err_ovf), 0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b1, 1'b0);
        checkOutput("udf_set_beats_clr", 32'(err_udf), 1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("udf_cleared", 32'(err_udf), 0);

        // Burst with the engine stalled: 1 in the operand register plus 8 queued.
        realMode = 1'b0;
        engStall = 1'b1;
        hsBase = hsCount;
        for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 16'(i), 1'b0, 1'b0, 1'b1);
        checkOutput("cmd_full_after_burst", 32'(cmd_full), 1);
        applyStimulus(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_set", 32'(err_ovf), 1);
        checkOutput("busy_burst", 32'(busy), 1);
        applyStimulus(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("ovf_cleared", 32'(err_ovf), 0);
        engStall = 1'b0;
        pushWhenRoom(16'h000A, 500);
        pushWhenRoom(16'h000B, 500);

        // Response FIFO fills after 8 results, and issue stops.
        waitHs(hsBase + 8, 1000);
        checkNoIssue = 1'b1;
        repeat (30) cycle();
        checkNoIssue = 1'b0;
        checkOutput("backpressure_hs", hsCount - hsBase, 8);
        checkOutput("rsp_full_not_empty", 32'(rsp_empty), 0);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("burst_first_result", lastPop, 16'hFFFE);
        waitHs(hsBase + 9, 300);
        repeat (20) cycle();
        checkOutput("one_more_issue", hsCount - hsBase, 9);
        drain(3000);

        // Random traffic against the stub engine.
        randomPhase(60);
        checkOutput("random_no_ovf", 32'(err_ovf), 0);
        checkOutput("random_no_udf", 32'(err_udf), 0);

        // Reset asserted while waiting on the engine result.
        engHoldOut = 1'b1;
        applyStimulus(1'b1, 16'h0030, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0050, 1'b0, 1'b0, 1'b1);
        begin
            int n = 0;
            while (!eng_ready_out && n < 200) begin
                cycle();
                n++;
            end
            if (!eng_ready_out) failNow("wait_state_timeout", n, 200);
        end
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midwait_ready_out", 32'(eng_ready_out), 0);
        checkOutput("midwait_rsp_empty", 32'(rsp_empty), 1);
        checkOutput("midwait_cmd_full", 32'(cmd_full), 0);
        checkOutput("midwait_busy", 32'(busy), 0);
        expQ.delete();
        issueQ.delete();
        outstanding = 1'b0;
        engHoldOut = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        checkResetState();

        // Recovery after reset.
        applyStimulus(1'b1, 16'h0004, 1'b0, 1'b0, 1'b1);
        waitRsp(200);
        applyStimulus(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("post_reset_result", lastPop, 16'hFFFB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
